// File: rtl/kernel2_udiv_pkg.sv
// Shared types and constants for the kernel2 sequential unsigned divider.
// Optional early-exit path is enabled by defining KERNEL2_UDIV_EARLY_EXIT_EN.
package kernel2_udiv_pkg;

  localparam int UDIV_DIN0_W = 24;
  localparam int UDIV_DIN1_W = 11;
  localparam int UDIV_DOUT_W = 13;

  typedef enum logic [1:0] {
    UDIV_IDLE = 2'd0,
    UDIV_RUN  = 2'd1,
    UDIV_DONE = 2'd2
  } udiv_state_e;

  // Counter must hold the full dividend width, so one extra code point.
  function automatic int udiv_cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/kernel2_udiv_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor if it fits.
module kernel2_udiv_step #(
  parameter int W = 11
) (
  input  logic [W-1:0] r_in,
  input  logic         q_msb,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] r_out,
  output logic         qbit
);

  logic [W:0] shifted;
  logic [W:0] trial;
  logic [W:0] r_full;
  logic       unused_r_msb;

  assign shifted = {r_in, q_msb};
  assign trial   = shifted - {1'b0, divisor};
  assign qbit    = (shifted >= {1'b0, divisor});
  assign r_full  = qbit ? trial : shifted;
  // r_in < divisor on entry, so the kept remainder always fits in W bits.
  assign r_out        = r_full[W-1:0];
  assign unused_r_msb = r_full[W];

endmodule

// File: rtl/kernel2_udiv_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock, driven
// by an ap_start/ap_done handshake. Define KERNEL2_UDIV_EARLY_EXIT_EN to skip
// the iteration when din0 < din1.
module kernel2_udiv_seq
  import kernel2_udiv_pkg::*;
#(
  parameter logic [31:0] ID         = 32'd1,
  parameter int          din0_WIDTH = UDIV_DIN0_W,
  parameter int          din1_WIDTH = UDIV_DIN1_W,
  parameter int          dout_WIDTH = UDIV_DOUT_W
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  ap_start,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  ap_idle,
  output logic                  ap_done,
  output logic [dout_WIDTH-1:0] quot,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  ovf,
  output logic                  dbz,
  output logic [1:0]            dbg_state
);

  // Handshake: ap_start is sampled only while ap_idle=1; ap_done is a single
  // cycle pulse during which quot/rem/ovf/dbz are valid, and they hold after.

  localparam int CNT_W = udiv_cnt_w(din0_WIDTH);

  udiv_state_e           state_q, state_d;
  logic [din0_WIDTH-1:0] q_q, q_d, q_next;
  logic [din1_WIDTH-1:0] r_q, r_d;
  logic [din1_WIDTH-1:0] div_q, div_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [dout_WIDTH-1:0] quot_q, quot_d;
  logic [din1_WIDTH-1:0] rem_q, rem_d;
  logic                  ovf_q, ovf_d;
  logic                  dbz_q, dbz_d;
  logic [din1_WIDTH-1:0] step_r;
  logic                  step_qbit;
  logic                  unused_id;

  assign unused_id = ^ID;

  kernel2_udiv_step #(.W(din1_WIDTH)) u_step (
    .r_in    (r_q),
    .q_msb   (q_q[din0_WIDTH-1]),
    .divisor (div_q),
    .r_out   (step_r),
    .qbit    (step_qbit)
  );

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
    dbz_d   = dbz_q;
    q_next  = {q_q[din0_WIDTH-2:0], step_qbit};
    case (state_q)
      UDIV_IDLE: begin
        if (ap_start) begin
          div_d = din1;
          r_d   = '0;
          q_d   = din0;
          cnt_d = CNT_W'(din0_WIDTH);
          if (din1 == '0) begin
            state_d = UDIV_DONE;
            quot_d  = '1;
            rem_d   = din0[din1_WIDTH-1:0];
            ovf_d   = 1'b0;
            dbz_d   = 1'b1;
          end
`ifdef KERNEL2_UDIV_EARLY_EXIT_EN
          else if (din0 < din0_WIDTH'(din1)) begin
            state_d = UDIV_DONE;
            quot_d  = '0;
            rem_d   = din0[din1_WIDTH-1:0];
            ovf_d   = 1'b0;
            dbz_d   = 1'b0;
          end
`endif
          else begin
            state_d = UDIV_RUN;
          end
        end
      end
      UDIV_RUN: begin
        r_d   = step_r;
        q_d   = q_next;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          // Last step: results are latched on the way into DONE.
          state_d = UDIV_DONE;
          rem_d   = step_r;
          dbz_d   = 1'b0;
          if ((q_next >> dout_WIDTH) != '0) begin
            quot_d = '1;
            ovf_d  = 1'b1;
          end else begin
            quot_d = q_next[dout_WIDTH-1:0];
            ovf_d  = 1'b0;
          end
        end
      end
      UDIV_DONE: state_d = UDIV_IDLE;
      default:   state_d = UDIV_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= UDIV_IDLE;
      q_q     <= '0;
      r_q     <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
      dbz_q   <= dbz_d;
    end
  end

  assign ap_idle   = (state_q == UDIV_IDLE);
  assign ap_done   = (state_q == UDIV_DONE);
  assign quot      = quot_q;
  assign rem       = rem_q;
  assign ovf       = ovf_q;
  assign dbz       = dbz_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_kernel2_udiv_seq.sv
// Directed-vector bench for kernel2_udiv_seq with hand-computed expectations.
module tb_kernel2_udiv_seq;
  import kernel2_udiv_pkg::*;

  localparam int LIMIT = 60;
`ifdef KERNEL2_UDIV_EARLY_EXIT_EN
  localparam int SMALL_LAT = 1;
`else
  localparam int SMALL_LAT = 25;
`endif

  logic        ap_clk;
  logic        ap_rst_n;
  logic        ap_start;
  logic [23:0] din0;
  logic [10:0] din1;
  logic        ap_idle;
  logic        ap_done;
  logic [12:0] quot;
  logic [10:0] rem;
  logic        ovf;
  logic        dbz;
  logic [1:0]  dbg_state;

  int errors;
  int checks;

  kernel2_udiv_seq dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .ap_start  (ap_start),
    .din0      (din0),
    .din1      (din1),
    .ap_idle   (ap_idle),
    .ap_done   (ap_done),
    .quot      (quot),
    .rem       (rem),
    .ovf       (ovf),
    .dbz       (dbz),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one operation; cycle 1 is the cycle right after the sampling edge.
  task automatic run_op(input string tag, input logic [23:0] d0, input logic [10:0] d1,
                        input int e_quot, input int e_rem, input int e_ovf,
                        input int e_dbz, input int e_lat);
    int cyc;
    check({tag, "_idle_pre"}, 32'(ap_idle), 1);
    din0 = d0;
    din1 = d1;
    ap_start = 1'b1;
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
    cyc = 1;
    while (!ap_done && cyc < LIMIT) begin
      @(posedge ap_clk); #1;
      cyc++;
    end
    check({tag, "_lat"}, 32'(cyc), 32'(e_lat));
    check({tag, "_quot"}, 32'(quot), 32'(e_quot));
    check({tag, "_rem"}, 32'(rem), 32'(e_rem));
    check({tag, "_ovf"}, 32'(ovf), 32'(e_ovf));
    check({tag, "_dbz"}, 32'(dbz), 32'(e_dbz));
    @(posedge ap_clk); #1;
    check({tag, "_done_pulse"}, 32'(ap_done), 0);
    check({tag, "_idle_post"}, 32'(ap_idle), 1);
  endtask

  initial begin
    int cyc;
    int done_cnt;
    int first_cyc, second_cyc;
    logic [12:0] first_q, second_q;
    logic [10:0] first_r, second_r;

    errors   = 0;
    checks   = 0;
    ap_rst_n = 1'b0;
    ap_start = 1'b0;
    din0     = '0;
    din1     = '0;
    repeat (3) @(posedge ap_clk);
    #1;
    check("rst_quot", 32'(quot), 0);
    check("rst_rem", 32'(rem), 0);
    check("rst_ovf", 32'(ovf), 0);
    check("rst_dbz", 32'(dbz), 0);
    check("rst_idle", 32'(ap_idle), 1);
    check("rst_done", 32'(ap_done), 0);
    check("rst_state", 32'(dbg_state), 32'(UDIV_IDLE));
    ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;

    run_op("max_exact", 24'd8382465, 11'd2047, 4095, 0, 0, 0, 25);
    run_op("div7", 24'd1000, 11'd7, 142, 6, 0, 0, 25);
    run_op("sat", 24'd8388608, 11'd1, 8191, 0, 1, 0, 25);
    run_op("dbz", 24'd12345, 11'd0, 8191, 57, 0, 1, 1);

    // Mid-run reset: outputs must hold until then, then clear without a done.
    din0 = 24'd1000;
    din1 = 11'd7;
    ap_start = 1'b1;
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
    cyc = 1;
    while (cyc < 10) begin
      if (cyc == 5) begin
        check("hold_quot", 32'(quot), 8191);
        check("hold_dbz", 32'(dbz), 1);
        check("hold_idle", 32'(ap_idle), 0);
      end
      @(posedge ap_clk); #1;
      cyc++;
    end
    ap_rst_n = 1'b0;
    #1;
    check("mrst_quot", 32'(quot), 0);
    check("mrst_rem", 32'(rem), 0);
    check("mrst_dbz", 32'(dbz), 0);
    check("mrst_idle", 32'(ap_idle), 1);
    check("mrst_done", 32'(ap_done), 0);
    @(posedge ap_clk); #1;
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge ap_clk); #1;
      if (ap_done) done_cnt++;
    end
    check("mrst_no_done", 32'(done_cnt), 0);

    run_op("small", 24'd50, 11'd100, 0, 50, 0, 0, SMALL_LAT);

    // Start held high; operands change mid-run and must only affect op two.
    din0 = 24'd1000;
    din1 = 11'd7;
    ap_start = 1'b1;
    @(posedge ap_clk); #1;
    first_cyc = 0;
    second_cyc = 0;
    first_q = '0;
    first_r = '0;
    second_q = '0;
    second_r = '0;
    for (int c = 1; c <= 58; c++) begin
      if (c == 2) check("b2b_busy", 32'(ap_idle), 0);
      if (c == 5) begin
        din0 = 24'd8382465;
        din1 = 11'd2047;
      end
      if (c == 26) check("b2b_idle_gap", 32'(ap_idle), 1);
      if (c == 27) ap_start = 1'b0;
      if (ap_done && first_cyc == 0) begin
        first_cyc = c;
        first_q = quot;
        first_r = rem;
      end else if (ap_done && second_cyc == 0) begin
        second_cyc = c;
        second_q = quot;
        second_r = rem;
      end
      @(posedge ap_clk); #1;
    end
    ap_start = 1'b0;
    check("b2b_first_cyc", 32'(first_cyc), 25);
    check("b2b_first_quot", 32'(first_q), 142);
    check("b2b_first_rem", 32'(first_r), 6);
    check("b2b_second_cyc", 32'(second_cyc), 51);
    check("b2b_second_quot", 32'(second_q), 4095);
    check("b2b_second_rem", 32'(second_r), 0);
    check("b2b_final_idle", 32'(ap_idle), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
